// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first, with hold stall and done pulse
module piso_tx #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [DW-1:0] dat,
  input  logic          hold,
  output logic          rdy,
  output logic          ser_out,
  output logic          ser_enb,
  output logic          done
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [DW-1:0] sreg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (vld) begin
            sreg  <= dat;
            cnt   <= CW'(DW);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // hold freezes everything; the current bit stays on ser_out
          if (!hold) begin
            sreg <= {sreg[DW-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rdy     = (state == IDLE);
  assign ser_out = (state == SHIFT) & sreg[DW-1];
  assign ser_enb = (state == SHIFT) & ~hold;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized and directed bench for piso_tx at DW=4 and DW=8
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       vld  [2];
  logic       hold [2];
  logic [7:0] dat  [2];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 4 : 8;
    logic         rdy, ser_out, ser_enb, done;
    bit           q[$];
    int           qs = 0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] sipo = '0;
    bit           done_exp = 1'b0;

    piso_tx #(.DW(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .vld    (vld[g]),
      .dat    (dat[g][W-1:0]),
      .hold   (hold[g]),
      .rdy    (rdy),
      .ser_out(ser_out),
      .ser_enb(ser_enb),
      .done   (done)
    );

    // reference: a word becomes a queue of bits; each unheld cycle pops one
    always @(negedge clk) begin
      if (!rst) begin
        q.delete();
        done_exp = 1'b0;
      end
      check($sformatf("rdy_w%0d", W), 32'(rdy), 32'(q.size() == 0));
      check($sformatf("enb_w%0d", W), 32'(ser_enb), 32'(q.size() > 0 && !hold[g]));
      check($sformatf("out_w%0d", W), 32'(ser_out), 32'(q.size() > 0 ? q[0] : 1'b0));
      check($sformatf("done_w%0d", W), 32'(done), 32'(done_exp));
      if (done)
        check($sformatf("sipo_w%0d", W), 32'(sipo), 32'(last_word));
      if (ser_enb)
        sipo = {sipo[W-2:0], ser_out};
      done_exp = 1'b0;
      if (rst) begin
        if (q.size() > 0) begin
          if (!hold[g]) begin
            void'(q.pop_front());
            if (q.size() == 0) done_exp = 1'b1;
          end
        end else if (vld[g]) begin
          for (int i = W - 1; i >= 0; i--) q.push_back(dat[g][i]);
          last_word = dat[g][W-1:0];
        end
      end
      qs = q.size();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // leaves vld high after the accepting edge so callers can chain words
  task automatic push(input int l, input logic [7:0] w);
    vld[l] = 1'b1;
    dat[l] = w;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((l == 0) ? lane[0].rdy : lane[1].rdy) begin
        cyc();
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      vld[l]  = 1'b0;
      hold[l] = 1'b0;
      dat[l]  = 8'h00;
    end
    idle(2);
    rst = 1'b1;
    idle(1);

    push(0, 8'h0B); vld[0] = 1'b0; idle(6);

    push(0, 8'h0C); push(0, 8'h03); vld[0] = 1'b0; idle(6);

    push(0, 8'h09); vld[0] = 1'b0; cyc();
    hold[0] = 1'b1; idle(3);
    hold[0] = 1'b0; idle(6);

    push(0, 8'h0F); dat[0] = 8'h00; idle(2);
    vld[0] = 1'b0; idle(6);

    push(0, 8'h0A); vld[0] = 1'b0; cyc();
    rst = 1'b0; cyc();
    rst = 1'b1;
    push(0, 8'h06); vld[0] = 1'b0; idle(6);

    hold[0] = 1'b1;
    push(0, 8'h05); hold[0] = 1'b0; vld[0] = 1'b0; idle(6);

    push(1, 8'hA5); vld[1] = 1'b0; idle(10);

    repeat (1500) begin
      for (int l = 0; l < 2; l++) begin
        vld[l]  = ($urandom_range(0, 2) != 0);
        dat[l]  = 8'($urandom);
        hold[l] = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end

    for (int l = 0; l < 2; l++) begin
      vld[l]  = 1'b0;
      hold[l] = 1'b0;
    end
    idle(12);
    check("drain_w4", 32'(lane[0].qs), 32'd0);
    check("drain_w8", 32'(lane[1].qs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter DW, default 4, giving the parallel word width in bits; legal range DW >= 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port vld  input  1  parallel word valid from the upstream source.
REQ-005 SHALL have port dat  input  DW  parallel word; sampled only on accept.
REQ-006 SHALL have port hold  input  1  stall request; freezes shifting while high.
REQ-007 SHALL have port rdy  output  1  block can accept a word this cycle.
REQ-008 SHALL have port ser_out  output  1  serial data bit, MSB first, for the downstream shift-left SIPO "inp".
REQ-009 SHALL have port ser_enb  output  1  serial bit valid strobe, for the downstream SIPO "enb".
REQ-010 SHALL have port done  output  1  single-cycle pulse; a complete word has been sent.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 SHALL hold an internal DW-bit shift register and a bit counter of width $clog2(DW)+1.
REQ-013 In IDLE: rdy=1, ser_enb=0, ser_out=0.
REQ-014 Accept condition: vld=1 and rdy=1 at a rising edge.
REQ-015 On accept: load dat into the shift register, set the counter to DW, and move to SHIFT.
REQ-016 In SHIFT: rdy=0; ser_out = shift register MSB; ser_enb = NOT hold.
REQ-017 Each SHIFT edge with hold=0: shift the register left one bit with 0 filled into the LSB, and decrement the counter.
REQ-018 Each SHIFT edge with hold=1: register, counter and state are unchanged; the current bit is re-presented with ser_enb=0.
REQ-019 Exactly DW cycles with ser_enb=1 SHALL occur per accepted word, carrying dat[DW-1] down to dat[0] in order.
REQ-020 Latency: a word accepted at edge N presents its first bit (ser_enb=1) in the cycle after N, given hold=0.
REQ-021 The SHIFT edge that consumes the last bit (counter 1 to 0) SHALL return the FSM to IDLE and set done=1 for exactly one cycle.
REQ-022 In that done cycle, rdy=1, so a new word may be accepted; minimum word spacing is DW+1 cycles.
REQ-023 vld asserted during SHIFT SHALL be ignored: no load and no corruption; upstream must hold vld until rdy.
REQ-024 hold asserted in IDLE SHALL have no effect; accept proceeds normally.
REQ-025 hold asserted on the last bit delays both the done pulse and the return to IDLE until the first edge with hold=0.
REQ-026 dat changes while not accepting SHALL have no effect on ser_out.
REQ-027 Every output SHALL be a function of registered state only, with no combinational path from vld, dat or hold, except ser_enb from hold.
REQ-028 Output contract: a downstream DW-bit shift-left SIPO driven by ser_out/ser_enb SHALL hold the accepted dat once done is seen.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, shift register 0, counter 0 and done 0.
REQ-030 During reset, outputs SHALL read rdy=1, ser_out=0, ser_enb=0, done=0.
REQ-031 Reset asserted mid-word SHALL abort the word with no done pulse; the first edge after release is in IDLE.

Verification
REQ-032 DW=4, hold=0, accept dat=4'b1011 -> ser_out 1,0,1,1 on four consecutive ser_enb=1 cycles; done=1 in the next cycle; a chained SIPO out=4'b1011.
REQ-033 Back-to-back 4'b1100 then 4'b0011 with vld held high -> second accept occurs in the done cycle; serial stream 1,1,0,0 then 0,0,1,1 with exactly one ser_enb=0 gap cycle.
REQ-034 Accept 4'b1001, with hold=1 for 3 cycles after the second bit -> ser_enb=0 and ser_out=0 during the stall; the resumed stream completes 0,1; the chained SIPO reads 4'b1001.
REQ-035 During SHIFT of 4'b1111, drive vld=1 with dat=4'b0000 -> rdy=0, no load, and four 1s are sent.
REQ-036 Assert rst low after the second bit of 4'b1010 -> immediate rdy=1, ser_enb=0, no done pulse; a subsequent accept of 4'b0110 sends 0,1,1,0 correctly.
REQ-037 Repeat REQ-032 with DW=8 and dat=8'hA5 -> bits 1,0,1,0,0,1,0,1, then done after the 8th ser_enb cycle.
